// File: rtl/warmboot_sequencer.sv
// Two debounced buttons drive a 3-state warm-boot sequencer.
// The first effect of a press appears DEBOUNCE_CYCLES+3 edges after the raw level is first sampled high.
// There is no backpressure: a press that arrives in a state that ignores it is dropped.

module wb_debounce #(
    parameter logic [15:0] CYCLES = 16'd50000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw_i,
    output logic press_o
);
    localparam logic [15:0] LAST = CYCLES - 16'd1;

    logic        sync1_q, sync2_q, level_q, press_q;
    logic [15:0] cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= 16'd0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= 16'd0;
            end else if (cnt_q == LAST) begin
                // Only the rising edge of the debounced level is reported.
                level_q <= ~level_q;
                cnt_q   <= 16'd0;
                press_q <= ~level_q;
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign press_o = press_q;
endmodule

module warmboot_sequencer #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          HOLD_LOG2       = 24,
    parameter logic [1:0]  INIT_IMAGE      = 2'd1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn_next,
    input  logic       btn_boot,
    output logic [1:0] image_sel,
    output logic       boot,
    output logic [4:0] led,
    output logic       busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRE  = 2'd2
    } state_t;

    localparam logic [HOLD_LOG2-1:0] REM_ONE = HOLD_LOG2'(1);

    logic next_press, boot_press;

    wb_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clock   (clock),
        .reset_n (reset_n),
        .raw_i   (btn_next),
        .press_o (next_press)
    );

    wb_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_boot (
        .clock   (clock),
        .reset_n (reset_n),
        .raw_i   (btn_boot),
        .press_o (boot_press)
    );

    state_t               state_q;
    logic [HOLD_LOG2-1:0] rem_q;
    logic [HOLD_LOG2-1:0] rem_dec;
    logic [1:0]           sel_q, sel_inc;
    logic                 boot_q, busy_q;
    logic [4:0]           led_q;

    assign rem_dec = rem_q - REM_ONE;
    assign sel_inc = sel_q + 2'd1;

    // Blink from a mid bit of rem, thermometer from its top two bits.
    function automatic logic [4:0] armed_led(input logic [HOLD_LOG2-1:0] r);
        logic [3:0] th;
        case (r[HOLD_LOG2-1:HOLD_LOG2-2])
            2'b11:   th = 4'b1111;
            2'b10:   th = 4'b0111;
            2'b01:   th = 4'b0011;
            default: th = 4'b0001;
        endcase
        return {r[HOLD_LOG2-3], th};
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sel_q   <= INIT_IMAGE;
            boot_q  <= 1'b0;
            busy_q  <= 1'b0;
            led_q   <= {3'b000, INIT_IMAGE};
            rem_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (boot_press) begin
                        state_q <= ARMED;
                        rem_q   <= '1;
                        busy_q  <= 1'b1;
                        led_q   <= armed_led('1);
                    end else if (next_press) begin
                        sel_q <= sel_inc;
                        led_q <= {3'b000, sel_inc};
                    end
                end
                ARMED: begin
                    // Cancel beats the expiry when both land on the same edge.
                    if (boot_press) begin
                        state_q <= IDLE;
                        rem_q   <= '0;
                        busy_q  <= 1'b0;
                        led_q   <= {3'b000, sel_q};
                    end else if (rem_q == '0) begin
                        state_q <= FIRE;
                        boot_q  <= 1'b1;
                        led_q   <= 5'b11111;
                    end else begin
                        rem_q <= rem_dec;
                        led_q <= armed_led(rem_dec);
                    end
                end
                FIRE: begin
                    boot_q <= 1'b1;
                    busy_q <= 1'b1;
                    led_q  <= 5'b11111;
                end
                default: begin
                    state_q <= IDLE;
                    boot_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    rem_q   <= '0;
                    led_q   <= {3'b000, sel_q};
                end
            endcase
        end
    end

    assign image_sel = sel_q;
    assign boot      = boot_q;
    assign led       = led_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_warmboot_sequencer.sv
// Directed bench for warmboot_sequencer with DEBOUNCE_CYCLES=4, HOLD_LOG2=4, INIT_IMAGE=1.
module tb_warmboot_sequencer;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_boot = 1'b0;
    logic [1:0] image_sel;
    logic       boot;
    logic [4:0] led;
    logic       busy;

    int checks = 0;
    int failures = 0;

    warmboot_sequencer #(
        .DEBOUNCE_CYCLES (16'd4),
        .HOLD_LOG2       (4),
        .INIT_IMAGE      (2'd1)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .btn_next  (btn_next),
        .btn_boot  (btn_boot),
        .image_sel (image_sel),
        .boot      (boot),
        .led       (led),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the falling edge after n more rising edges.
    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press_next();
        btn_next = 1'b1;
        cyc(10);
        btn_next = 1'b0;
        cyc(12);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
    endtask

    logic [1:0] wrap_exp [4] = '{2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        cyc(2);
        chk("rst_sel",  32'(image_sel), 32'd1);
        chk("rst_boot", 32'(boot),      32'd0);
        chk("rst_busy", 32'(busy),      32'd0);
        chk("rst_led",  32'(led),       32'h01);
        reset_n = 1'b1;
        cyc(1);

        // Clean press: the change lands on the 7th edge and only once.
        btn_next = 1'b1;
        cyc(6);
        chk("next_e6", 32'(image_sel), 32'd1);
        cyc(1);
        chk("next_e7", 32'(image_sel), 32'd2);
        chk("next_led", 32'(led), 32'h02);
        cyc(3);
        btn_next = 1'b0;
        cyc(12);
        chk("next_once", 32'(image_sel), 32'd2);

        // Bounce never stays stable long enough to register.
        for (int i = 0; i < 10; i++) begin
            btn_next = 1'b1;
            cyc(2);
            btn_next = 1'b0;
            cyc(2);
        end
        cyc(12);
        chk("bounce", 32'(image_sel), 32'd2);

        do_reset();
        chk("rst2_sel", 32'(image_sel), 32'd1);
        for (int i = 0; i < 4; i++) begin
            press_next();
            chk($sformatf("wrap%0d", i), 32'(image_sel), 32'(wrap_exp[i]));
        end
        press_next();
        chk("sel_pre_boot", 32'(image_sel), 32'd2);

        // Full armed countdown, entry E is the 7th edge after the raw rise.
        btn_boot = 1'b1;
        cyc(7);
        chk("arm_busy",   32'(busy),     32'd1);
        chk("arm_therm0", 32'(led[3:0]), 32'hF);
        chk("arm_boot0",  32'(boot),     32'd0);
        cyc(2);
        chk("arm_led_e2", 32'(led), 32'h0F);
        cyc(1);
        btn_boot = 1'b0;
        cyc(1);
        chk("arm_therm4", 32'(led[3:0]), 32'h7);
        cyc(4);
        chk("arm_therm8", 32'(led[3:0]), 32'h3);
        chk("arm_sel",    32'(image_sel), 32'd2);
        cyc(4);
        chk("arm_therm12", 32'(led[3:0]), 32'h1);
        cyc(3);
        chk("arm_led_e15", 32'(led),  32'h01);
        chk("arm_boot15",  32'(boot), 32'd0);
        cyc(1);
        chk("fire_boot", 32'(boot), 32'd1);
        chk("fire_led",  32'(led),  32'h1F);
        chk("fire_busy", 32'(busy), 32'd1);
        press_next();
        chk("fire_sel",   32'(image_sel), 32'd2);
        chk("fire_hold",  32'(boot),      32'd1);

        // Asynchronous reset while firing, sampled before any rising edge.
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_boot", 32'(boot),      32'd0);
        chk("arst_sel",  32'(image_sel), 32'd1);
        chk("arst_busy", 32'(busy),      32'd0);
        chk("arst_led",  32'(led),       32'h01);
        @(negedge clock);
        reset_n = 1'b1;
        cyc(2);

        // Cancel 8 clocks into ARMED, with a next press ignored meanwhile.
        btn_boot = 1'b1;
        cyc(4);
        btn_boot = 1'b0;
        cyc(3);
        chk("can_arm", 32'(busy), 32'd1);
        btn_next = 1'b1;
        cyc(1);
        btn_boot = 1'b1;
        cyc(6);
        chk("can_e7_busy", 32'(busy),      32'd1);
        chk("can_e7_sel",  32'(image_sel), 32'd1);
        cyc(1);
        chk("can_busy", 32'(busy), 32'd0);
        chk("can_boot", 32'(boot), 32'd0);
        chk("can_led",  32'(led),  32'h01);
        cyc(2);
        btn_boot = 1'b0;
        btn_next = 1'b0;
        cyc(20);
        chk("can_after_boot", 32'(boot),      32'd0);
        chk("can_after_sel",  32'(image_sel), 32'd1);

        // Simultaneous presses in IDLE act as boot only.
        btn_boot = 1'b1;
        btn_next = 1'b1;
        cyc(7);
        chk("both_busy", 32'(busy),      32'd1);
        chk("both_sel",  32'(image_sel), 32'd1);
        btn_boot = 1'b0;
        btn_next = 1'b0;

        // Button held through reset registers DEBOUNCE_CYCLES+3 edges after release.
        @(negedge clock);
        reset_n = 1'b0;
        btn_next = 1'b1;
        cyc(2);
        reset_n = 1'b1;
        cyc(6);
        chk("held_e6", 32'(image_sel), 32'd1);
        cyc(1);
        chk("held_e7", 32'(image_sel), 32'd2);
        btn_next = 1'b0;
        cyc(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
